// File: rtl/des_key_rotator.sv
// des_key_rotator: DES C/D key rotation stage feeding PC-2; DES_KEY_ROTATOR_PC2_EN adds an internal PC-2 subkey output
module des_key_rotator #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [55:0] key_in,
    output logic [55:0] round_key,
    output logic [3:0]  round_idx,
    output logic        round_valid,
    input  logic        round_ready,
    output logic        busy,
    output logic        done
`ifdef DES_KEY_ROTATOR_PC2_EN
    ,
    output logic [47:0] subkey
`endif
);
    typedef enum logic {IDLE, ROUND} state_t;
    state_t      state_q, state_d;
    logic [55:0] key_q, key_d;
    logic [3:0]  idx_q, idx_d, nidx;
    logic        dec_q, dec_d, done_q, done_d, accept, last, two;
    function automatic logic [27:0] rot(input logic [27:0] h, input logic right, input logic dbl);
        rot = right ? (dbl ? {h[1:0], h[27:2]} : {h[0], h[27:1]})
                    : (dbl ? {h[25:0], h[27:26]} : {h[26:0], h[27]});
    endfunction
    assign accept = state_q == ROUND && round_ready;
    assign last   = idx_q == 4'(NUM_ROUNDS - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end
    always_comb begin
        state_d = state_q == IDLE ? (start ? ROUND : IDLE) : (accept && last ? IDLE : ROUND);
    end
    // Rounds 2..16 use the same step size in both directions: 1 at rounds 2, 9, 16, else 2.
    always_comb begin
        nidx   = idx_q + 4'd1;
        two    = !(nidx == 4'd1 || nidx == 4'd8 || nidx == 4'd15);
        key_d  = state_q == IDLE
               ? (start ? (decrypt ? key_in : {rot(key_in[55:28], 1'b0, 1'b0), rot(key_in[27:0], 1'b0, 1'b0)}) : key_q)
               : (accept && !last ? {rot(key_q[55:28], dec_q, two), rot(key_q[27:0], dec_q, two)} : key_q);
        idx_d  = state_q == IDLE ? 4'd0 : (accept ? nidx : idx_q);
        dec_d  = state_q == IDLE && start ? decrypt : dec_q;
        done_d = accept && last;
    end
    assign round_key   = key_q;
    assign round_idx   = idx_q;
    assign round_valid = state_q == ROUND;
    assign busy        = state_q == ROUND;
    assign done        = done_q;
`ifdef DES_KEY_ROTATOR_PC2_EN
    localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign subkey[47-i] = key_q[56-PC2[i]];
    end
`endif
endmodule

// File: tb/tb_des_key_rotator.sv
// tb_des_key_rotator: randomized schedule runs checked against a cumulative-shift reference model
module tb_des_key_rotator;
    logic        clk = 1'b0, rst, start, decrypt, round_ready;
    logic [55:0] key_in, round_key;
    logic [3:0]  round_idx;
    logic        round_valid, busy, done;
`ifdef DES_KEY_ROTATOR_PC2_EN
    logic [47:0] subkey;
`endif
    int checks = 0, errors = 0;
    localparam logic [55:0] KREF = 56'hF0CCAAF556678F;
    localparam int ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int DECS [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_rotator dut (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_in(key_in),
        .round_key(round_key), .round_idx(round_idx), .round_valid(round_valid),
        .round_ready(round_ready), .busy(busy), .done(done)
`ifdef DES_KEY_ROTATOR_PC2_EN
        , .subkey(subkey)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] rl(input logic [27:0] h, input int s);
        logic [55:0] dd;
        dd = {h, h};
        return dd[55-s -: 28];
    endfunction

    function automatic logic [55:0] model(input logic [55:0] k, input logic d, input int idx);
        int s = 0;
        for (int i = 0; i <= idx; i++) s += d ? DECS[i] : ENC[i];
        s = d ? (28 - s % 28) % 28 : s % 28;
        return {rl(k[55:28], s), rl(k[27:0], s)};
    endfunction

    // mode: 0 always ready, 1 random ready + start on final accept, 2 backpressure at idx 3,
    // 3 reset at idx 7, 4 start with another key at idx 5
    task automatic run(input logic [55:0] k, input logic d, input int mode);
        int exp_r = 0, hold = 0;
        bit fin = 0, bp_done = 0, rdy, prev_stall = 0;
        logic [55:0] pk;
        logic [3:0] pi;
        start = 1'b1; key_in = k; decrypt = d;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            if (exp_r == 16) begin
                start = 1'b0;
                chk("done", 64'(done), 1);
                chk("end_valid", 64'(round_valid), 0);
                chk("end_busy", 64'(busy), 0);
                fin = 1;
            end else begin
                start = 1'b0;
                chk("valid", 64'(round_valid), 1);
                chk("busy", 64'(busy), 1);
                chk("done_low", 64'(done), 0);
                chk("idx", 64'(round_idx), 64'(exp_r));
                chk("key", 64'(round_key), 64'(model(k, d, exp_r)));
                if (prev_stall) begin
                    chk("stall_key", 64'(round_key), 64'(pk));
                    chk("stall_idx", 64'(round_idx), 64'(pi));
                end
                if (k == KREF && exp_r == 0) chk("lit_r1", 64'(round_key), d ? 64'(KREF) : 64'h00E19955FAACCF1E);
                if (k == KREF && exp_r == 15) chk("lit_r16", 64'(round_key), d ? 64'h00E19955FAACCF1E : 64'(KREF));
`ifdef DES_KEY_ROTATOR_PC2_EN
                if (k == KREF && !d && exp_r == 0) chk("subkey_r1", 64'(subkey), 64'h1B02EFFC7072);
`endif
                if (mode == 3 && exp_r == 7) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_key", 64'(round_key), 0);
                    chk("rst_idx", 64'(round_idx), 0);
                    chk("rst_valid", 64'(round_valid), 0);
                    chk("rst_busy", 64'(busy), 0);
                    chk("rst_done", 64'(done), 0);
                    @(negedge clk);
                    chk("rst_nodone", 64'(done), 0);
                    chk("rst_idle", 64'(round_valid), 0);
                    fin = 1;
                end else begin
                    if (mode == 2 && exp_r == 3 && !bp_done) begin hold = 5; bp_done = 1; end
                    rdy = mode == 1 ? $urandom_range(0, 3) != 0 : 1'b1;
                    if (hold > 0) begin rdy = 0; hold--; end
                    if ((mode == 4 && exp_r == 5) || (mode == 1 && exp_r == 15 && rdy)) begin
                        start = 1'b1; key_in = ~k; decrypt = ~d;
                    end
                    round_ready = rdy;
                    prev_stall = !rdy;
                    pk = round_key; pi = round_idx;
                    if (rdy) exp_r++;
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; round_ready = 1'b0; key_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_key", 64'(round_key), 0);
        chk("reset_idx", 64'(round_idx), 0);
        chk("reset_valid", 64'(round_valid), 0);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_done", 64'(done), 0);
`ifdef DES_KEY_ROTATOR_PC2_EN
        chk("reset_subkey", 64'(subkey), 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        run(KREF, 1'b0, 0);
        run(KREF, 1'b1, 0);
        run(KREF, 1'b0, 2);
        run({$urandom, $urandom}, 1'($urandom), 3);
        run(KREF, 1'b0, 0);
        run({$urandom, $urandom}, 1'b0, 4);
        for (int n = 0; n < 8; n++) run({$urandom, $urandom}, 1'($urandom), 1);
        @(negedge clk);
        start = 1'b0;
        chk("final_idle", 64'(round_valid), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
